// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with multi-cycle grant hold.
// A grant is kept until the owner pulses done, drops its request, or holds
// the resource for MAX_HOLD consecutive cycles (MAX_HOLD = 0 disables that).
// On release the pointer moves past the old owner and the next winner is
// granted at the same edge, so there is no idle cycle between owners.
//
// state | meaning
// IDLE  | no grant active, arbitrate from ptr_q on any request
// OWN   | gnt_q one-hot on owner gnt_id_q, hold counter running
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N-1:0]                       req_i,
    input  logic [N-1:0]                       done_i,
    output logic [N-1:0]                       gnt_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id_o,
    output logic                               busy_o,
    output logic                               timeout_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   id_q, id_d;
    logic            timeout_q, timeout_d;

    logic            rel_done, rel_drop, rel_to, rel_any;
    logic [IW-1:0]   ptr_rel;
    logic [IW-1:0]   arb_base;
    logic            hi_found, lo_found;
    logic [IW-1:0]   hi_idx, lo_idx, win_idx;

    // Release conditions for the current owner and the pointer it leaves behind.
    always_comb begin
        rel_done = done_i[id_q];
        rel_drop = !req_i[id_q];
        rel_to   = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);
        rel_any  = rel_done || rel_drop || rel_to;
        ptr_rel  = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
        arb_base = (state_q == OWN) ? ptr_rel : ptr_q;
    end

    // Circular first-set scan from arb_base: lowest request at or above the
    // base wins, otherwise wrap to the lowest request overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(k);
                if (k >= int'(arb_base)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(k);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                id_d  = '0;
                cnt_d = '0;
                if (lo_found) begin
                    state_d        = OWN;
                    gnt_d[win_idx] = 1'b1;
                    id_d           = win_idx;
                end
            end
            OWN: begin
                if (rel_any) begin
                    ptr_d     = ptr_rel;
                    timeout_d = rel_to && !rel_done && !rel_drop;
                    cnt_d     = '0;
                    gnt_d     = '0;
                    if (lo_found) begin
                        gnt_d[win_idx] = 1'b1;
                        id_d           = win_idx;
                    end else begin
                        state_d = IDLE;
                        id_d    = '0;
                    end
                end else if (MAX_HOLD != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = id_q;
    assign busy_o    = (state_q == OWN);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: behavioural ownership model checked every cycle,
// plus directed sequences with literal expectations.
module tb_rr_hold_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] done_i = '0;
    logic [N-1:0] gnt_o;
    logic [1:0]   gnt_id_o;
    logic         busy_o;
    logic         timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    rr_hold_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_id_o  (gnt_id_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 idle), cycles held so far, rotation pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    function automatic int pick(input int start, input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to    = 1'b0;
            m_owner = pick(m_ptr, req_i);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else begin
            bit d, r, t;
            d = done_i[m_owner];
            r = req_i[m_owner];
            t = (MH != 0) && (m_held == MH);
            if (d || !r || t) begin
                m_ptr   = (m_owner + 1) % N;
                m_to    = t && !d && r;
                m_owner = pick(m_ptr, req_i);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else begin
                m_to   = 1'b0;
                m_held = m_held + 1;
            end
        end
    end

    // Per-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (reset) begin
            chk("m_gnt", gnt_o, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_busy", busy_o, (m_owner >= 0) ? 32'd1 : 32'd0);
            chk("m_timeout", timeout_o, m_to ? 32'd1 : 32'd0);
            if (m_owner >= 0) chk("m_gnt_id", gnt_id_o, m_owner);
            chk("inv_onehot", $onehot0(gnt_o) ? 32'd1 : 32'd0, 32'd1);
            chk("inv_busy", busy_o, |gnt_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;

        // Reset with all requesting: nothing granted.
        req_i = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt_o, 4'b0000);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_id", gnt_id_o, 2'd0);
        chk("rst_to", timeout_o, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("first_gnt", gnt_o, 4'b0001);
        chk("first_id", gnt_id_o, 2'd0);
        chk("first_busy", busy_o, 1'b1);

        // Rotation: each owner holds two cycles then pulses done.
        for (int k = 0; k < 5; k++) begin
            chk("rr_c1", gnt_o, seq[k]);
            done_i = '0;
            @(negedge clk);
            chk("rr_c2", gnt_o, seq[k]);
            done_i = seq[k];
            @(negedge clk);
        end
        done_i = '0;
        chk("rr_next", gnt_o, 4'b0010);

        // Timeout with a sole requester: re-granted with a pulse.
        req_i = 4'b0100;
        @(negedge clk);
        chk("to_first", gnt_o, 4'b0100);
        chk("to_first_pulse", timeout_o, 1'b0);
        repeat (15) @(negedge clk);
        chk("to_c16", gnt_o, 4'b0100);
        chk("to_c16_pulse", timeout_o, 1'b0);
        @(negedge clk);
        chk("to_pulse", timeout_o, 1'b1);
        chk("to_regrant", gnt_o, 4'b0100);
        req_i = 4'b0110;
        @(negedge clk);
        chk("to_pulse_once", timeout_o, 1'b0);
        repeat (14) @(negedge clk);
        chk("to2_c16", gnt_o, 4'b0100);
        @(negedge clk);
        chk("to2_wrap_gnt", gnt_o, 4'b0010);
        chk("to2_wrap_id", gnt_id_o, 2'd1);
        chk("to2_pulse", timeout_o, 1'b1);

        // Request drop by owner 1 -> idle, then wrap to bit 0.
        req_i = 4'b0010;
        @(negedge clk);
        chk("drop_hold", gnt_o, 4'b0010);
        req_i = 4'b0000;
        @(negedge clk);
        chk("drop_gnt", gnt_o, 4'b0000);
        chk("drop_busy", busy_o, 1'b0);
        chk("drop_to", timeout_o, 1'b0);
        req_i = 4'b0011;
        @(negedge clk);
        chk("drop_wrap", gnt_o, 4'b0001);

        // Non-owner done/req changes ignored; hold counter keeps running.
        req_i = 4'b0100;
        @(negedge clk);
        chk("ign_own", gnt_o, 4'b0100);
        req_i = 4'b0101;
        @(negedge clk);
        done_i = 4'b1001;
        req_i  = 4'b0100;
        @(negedge clk);
        done_i = '0;
        chk("ign_gnt", gnt_o, 4'b0100);
        chk("ign_to", timeout_o, 1'b0);
        repeat (13) @(negedge clk);
        chk("ign_c16", gnt_o, 4'b0100);
        @(negedge clk);
        chk("ign_pulse", timeout_o, 1'b1);

        // Asynchronous reset mid-grant of owner 3.
        req_i = 4'b1000;
        @(negedge clk);
        chk("ar_own3", gnt_o, 4'b1000);
        #2 reset = 1'b0;
        #1;
        chk("ar_gnt", gnt_o, 4'b0000);
        chk("ar_busy", busy_o, 1'b0);
        chk("ar_id", gnt_id_o, 2'd0);
        req_i = 4'b1010;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ar_after", gnt_o, 4'b0010);

        // Done coinciding with the hold limit counts as done.
        repeat (15) @(negedge clk);
        chk("prec_c16", gnt_o, 4'b0010);
        done_i = 4'b0010;
        @(negedge clk);
        done_i = '0;
        chk("prec_gnt", gnt_o, 4'b1000);
        chk("prec_to", timeout_o, 1'b0);

        req_i = '0;
        repeat (20) @(negedge clk);
        chk("end_idle", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
